anu_decode_exec: RTL and testbench
==================================

// Module: anu_decode_exec
// PURPOSE
//  Single-cycle RV32I decode/execute slice of the AnuRV32 core: instruction decode + immediate
//  generation, 32-bit ALU with branch resolution, load-data extension, and write-back select.
//  Sits between the register file/PC and the data memory.
//  Decode/execute is combinational. One registered write-back stage feeds the register file.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  instr      in   32  current instruction word
//  pc         in   32  address of instr
//  rs1_data   in   32  register file read port 1
//  rs2_data   in   32  register file read port 2
//  load_data  in   32  raw data-memory read word
//  rs1,rs2,rd out  5   instr[19:15], instr[24:20], instr[11:7]
//  imm        out  32  decoded immediate
//  ctrl       out  16  [0]alu_r [1]i_frame [2]shift_i [3]ld [4]st [5]branch [6]jalr [7]jal [8]auipc [9]lui; [15:10]=0
//  alu_out    out  32  ALU result; also the memory address
//  zero       out  1   alu_out==0
//  br_taken   out  1   branch condition true (0 when not a branch)
//  mem_mode   out  2   store size: 00 none, 01 byte, 10 half, 11 word
//  wb_data    out  32  combinational write-back value
//  wen        out  1   register write enable, combinational
//  wb_q,rd_q,wen_q out 32/5/1  registered wb_data/rd/wen
// BEHAVIOUR
//  - rst_n=0: all outputs 0 asynchronously (combinational outputs gated); wb_q/rd_q/wen_q cleared.
//  - Opcodes: 0110011 alu_r; 0010011 i_frame (+shift_i if f3=001/101); 0000011 ld+i_frame;
//    0100011 st; 1100011 branch; 1100111 jalr+i_frame; 1101111 jal; 0010111 auipc; 0110111 lui.
//    Unknown opcode: ctrl=0, wen=0.
//  - imm: I {20{i31},i[31:20]}; S {i[31:25],i[11:7]} sext; B {i31,i7,i[30:25],i[11:8],0} sext;
//    U {i[31:12],12'b0}; J {i31,i[19:12],i20,i[30:21],0} sext; others 0.
//  - ALU operands: op1 = auipc ? pc : rs1_data. op2 = (i_frame|st|auipc) ? imm : rs2_data.
//  - ALU uop = funct3: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
//  - f7 (instr[30]) selects sub/sra; honoured only for alu_r and shift_i.
//    Shift amount = op2[4:0]. slt/sltu return 0/1.
//  - ld, st, auipc, jalr force add.
//  - Branch op by funct3: 00x -> sub, 10x -> slt, 11x -> sltu.
//    br_taken = (f3[2]^f3[0]) ? ~zero : zero (beq/bne/blt/bge/bltu/bgeu).
//    Branch funct3 010/011: br_taken=0.
//  - Load extension by funct3: 000 LB sext byte0, 001 LH sext half0, 010 LW bypass,
//    100 LBU zext byte0, 101 LHU zext half0; other values: bypass.
//  - mem_mode: st & f3=000 -> 01, 001 -> 10, 010 -> 11; otherwise 00.
//  - wb_data priority: jal|jalr -> pc+4; ld -> extended load; lui -> imm; else alu_out.
//  - wen = ~(st|branch) & valid opcode. Writes with rd=0 are the register file's concern.
//  - Rising clk: wb_q<=wb_data, rd_q<=rd, wen_q<=wen. Latency 1 cycle.
//  - Arithmetic wraps modulo 2^32; no overflow flag.
//  - rst_n deassertion takes effect at the next edge.
// TESTING
//  - addi x1,x0,-1 (0xFFF00093): imm=0xFFFFFFFF, alu_out=0xFFFFFFFF;
//    after one edge wb_q=0xFFFFFFFF, rd_q=1, wen_q=1.
//  - sub/sra: rs1=0x80000000, rs2=4, f7=1: sub -> 0x7FFFFFFC; sra -> 0xF8000000; srl (f7=0) -> 0x08000000.
//  - beq with rs1=rs2=5 -> zero=1, br_taken=1; bge rs1=-1, rs2=1 -> br_taken=0;
//    bgeu, same operands -> br_taken=1.
//  - lb/lhu, load_data=0x0000_80F0: lb -> wb_data=0xFFFFFFF0; lhu -> 0x000080F0; lw -> 0x000080F0.
//  - sw/sh/sb: mem_mode=11/10/01, wen=0, alu_out=rs1+S-imm; lui 0x12345 -> wb_data=0x12345000;
//    auipc at pc=0x100 imm=1 -> 0x1100; jal at pc=0x40 -> wb_data=0x44.
//  - Assert rst_n=0 mid-run: outputs and wb_q/rd_q/wen_q go 0 immediately, without a clk edge.

Source files
------------

// File: rtl/anu_decode_exec.sv
// anu_decode_exec: single-cycle RV32I decode/execute slice of the AnuRV32 core.
// Combinational decode, immediate generation, ALU with branch resolution,
// load-data extension and write-back select, plus one registered write-back stage.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   instr, pc               instruction word and its address
//   rs1_data, rs2_data      register file read data
//   load_data               raw data-memory read word
//   rs1, rs2, rd            register indices from instr
//   imm                     decoded immediate
//   ctrl                    decode flags [0]alu_r [1]i_frame [2]shift_i [3]ld [4]st
//                           [5]branch [6]jalr [7]jal [8]auipc [9]lui, [15:10]=0
//   alu_out, zero           ALU result (also memory address), result-is-zero
//   br_taken                branch condition true
//   mem_mode                store size: 00 none, 01 byte, 10 half, 11 word
//   wb_data, wen            combinational write-back value and enable
//   wb_q, rd_q, wen_q       write-back stage registers
module anu_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] load_data,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [15:0]     ctrl,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            br_taken,
  output logic [1:0]      mem_mode,
  output logic [XLEN-1:0] wb_data,
  output logic            wen,
  output logic [XLEN-1:0] wb_q,
  output logic [4:0]      rd_q,
  output logic            wen_q
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7_alt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7_alt = instr[30];

  logic is_alu_r, is_i_frame, is_shift_i, is_ld, is_st;
  logic is_branch, is_jalr, is_jal, is_auipc, is_lui, valid;

  always_comb begin
    is_alu_r   = 1'b0;
    is_i_frame = 1'b0;
    is_shift_i = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_branch  = 1'b0;
    is_jalr    = 1'b0;
    is_jal     = 1'b0;
    is_auipc   = 1'b0;
    is_lui     = 1'b0;
    case (opcode)
      7'b0110011: is_alu_r = 1'b1;
      7'b0010011: begin
        is_i_frame = 1'b1;
        is_shift_i = (f3 == 3'b001) || (f3 == 3'b101);
      end
      7'b0000011: begin
        is_ld      = 1'b1;
        is_i_frame = 1'b1;
      end
      7'b0100011: is_st = 1'b1;
      7'b1100011: is_branch = 1'b1;
      7'b1100111: begin
        is_jalr    = 1'b1;
        is_i_frame = 1'b1;
      end
      7'b1101111: is_jal = 1'b1;
      7'b0010111: is_auipc = 1'b1;
      7'b0110111: is_lui = 1'b1;
      default: ;
    endcase
  end

  assign valid = is_alu_r | is_i_frame | is_st | is_branch | is_jal | is_auipc | is_lui;

  logic [15:0] ctrl_i;
  assign ctrl_i = {6'b0, is_lui, is_auipc, is_jal, is_jalr, is_branch,
                   is_st, is_ld, is_shift_i, is_i_frame, is_alu_r};

  logic [XLEN-1:0] imm_i;
  always_comb begin
    imm_i = '0;
    if (is_i_frame)
      imm_i = {{20{instr[31]}}, instr[31:20]};
    else if (is_st)
      imm_i = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_branch)
      imm_i = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_auipc || is_lui)
      imm_i = {instr[31:12], 12'b0};
    else if (is_jal)
      imm_i = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  logic [XLEN-1:0] op1, op2;
  assign op1 = is_auipc ? pc : rs1_data;
  assign op2 = (is_i_frame || is_st || is_auipc) ? imm_i : rs2_data;

  // Address-forming instructions always add; branches remap funct3 onto the
  // compare that makes zero/~zero decide the outcome.
  logic [2:0] alu_f3;
  logic       alu_alt;
  always_comb begin
    alu_f3  = f3;
    alu_alt = 1'b0;
    if (is_ld || is_st || is_auipc || is_jalr) begin
      alu_f3 = 3'b000;
    end else if (is_branch) begin
      case (f3[2:1])
        2'b10:   alu_f3 = 3'b010;
        2'b11:   alu_f3 = 3'b011;
        default: begin
          alu_f3  = 3'b000;
          alu_alt = 1'b1;
        end
      endcase
    end else if (is_alu_r || is_shift_i) begin
      alu_alt = f7_alt;
    end
  end

  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_i;
  assign shamt = op2[4:0];

  always_comb begin
    alu_i = '0;
    case (alu_f3)
      3'b000: alu_i = alu_alt ? (op1 - op2) : (op1 + op2);
      3'b001: alu_i = op1 << shamt;
      3'b010: alu_i = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b011: alu_i = {{(XLEN-1){1'b0}}, (op1 < op2)};
      3'b100: alu_i = op1 ^ op2;
      3'b101: alu_i = alu_alt ? XLEN'($signed(op1) >>> shamt) : (op1 >> shamt);
      3'b110: alu_i = op1 | op2;
      default: alu_i = op1 & op2;
    endcase
  end

  logic zero_i, br_i;
  assign zero_i = (alu_i == '0);
  // beq/bge/bgeu take on zero, bne/blt/bltu on non-zero; 010/011 never take.
  assign br_i = is_branch && (f3[2:1] != 2'b01) && ((f3[2] ^ f3[0]) ? ~zero_i : zero_i);

  logic [XLEN-1:0] ld_ext;
  always_comb begin
    case (f3)
      3'b000:  ld_ext = {{24{load_data[7]}}, load_data[7:0]};
      3'b001:  ld_ext = {{16{load_data[15]}}, load_data[15:0]};
      3'b100:  ld_ext = {24'b0, load_data[7:0]};
      3'b101:  ld_ext = {16'b0, load_data[15:0]};
      default: ld_ext = load_data;
    endcase
  end

  logic [1:0] mem_mode_i;
  always_comb begin
    mem_mode_i = 2'b00;
    if (is_st) begin
      case (f3)
        3'b000:  mem_mode_i = 2'b01;
        3'b001:  mem_mode_i = 2'b10;
        3'b010:  mem_mode_i = 2'b11;
        default: mem_mode_i = 2'b00;
      endcase
    end
  end

  logic [XLEN-1:0] wb_i;
  logic            wen_i;
  always_comb begin
    if (is_jal || is_jalr) wb_i = pc + 32'd4;
    else if (is_ld)        wb_i = ld_ext;
    else if (is_lui)       wb_i = imm_i;
    else                   wb_i = alu_i;
  end
  assign wen_i = valid & ~(is_st | is_branch);

  // Combinational outputs are forced to zero while reset is held.
  assign rs1      = rst_n ? instr[19:15] : '0;
  assign rs2      = rst_n ? instr[24:20] : '0;
  assign rd       = rst_n ? instr[11:7]  : '0;
  assign imm      = rst_n ? imm_i        : '0;
  assign ctrl     = rst_n ? ctrl_i       : '0;
  assign alu_out  = rst_n ? alu_i        : '0;
  assign zero     = rst_n & zero_i;
  assign br_taken = rst_n & br_i;
  assign mem_mode = rst_n ? mem_mode_i   : '0;
  assign wb_data  = rst_n ? wb_i         : '0;
  assign wen      = rst_n & wen_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q  <= '0;
      rd_q  <= '0;
      wen_q <= 1'b0;
    end else begin
      wb_q  <= wb_i;
      rd_q  <= instr[11:7];
      wen_q <= wen_i;
    end
  end

endmodule

// File: tb/tb_anu_decode_exec.sv
// Directed-vector bench for anu_decode_exec with hand-computed expectations.
module tb_anu_decode_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc, rs1_data, rs2_data, load_data;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [15:0] ctrl;
  logic [31:0] alu_out;
  logic        zero, br_taken;
  logic [1:0]  mem_mode;
  logic [31:0] wb_data;
  logic        wen;
  logic [31:0] wb_q;
  logic [4:0]  rd_q;
  logic        wen_q;

  int n_chk  = 0;
  int n_pass = 0;

  anu_decode_exec dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .load_data(load_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ctrl(ctrl),
    .alu_out(alu_out), .zero(zero), .br_taken(br_taken), .mem_mode(mem_mode),
    .wb_data(wb_data), .wen(wen), .wb_q(wb_q), .rd_q(rd_q), .wen_q(wen_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Apply a vector mid-cycle and let the combinational logic settle.
  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] l);
    instr = i; pc = p; rs1_data = a; rs2_data = b; load_data = l;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'hFFF00093, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst imm",     imm, 32'h0);
    chk("rst alu",     alu_out, 32'h0);
    chk("rst wb",      wb_data, 32'h0);
    chk("rst ctrl",    {16'h0, ctrl}, 32'h0);
    chk("rst wen/rd",  {26'h0, wen, rd}, 32'h0);
    chk("rst wb_q",    wb_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,-1
    drive(32'hFFF00093, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("addi imm",  imm, 32'hFFFFFFFF);
    chk("addi alu",  alu_out, 32'hFFFFFFFF);
    chk("addi ctrl", {16'h0, ctrl}, 32'h0002);
    chk("addi rd",   {27'h0, rd}, 32'd1);
    @(posedge clk); #1;
    chk("addi wb_q",  wb_q, 32'hFFFFFFFF);
    chk("addi rd_q",  {27'h0, rd_q}, 32'd1);
    chk("addi wen_q", {31'h0, wen_q}, 32'd1);

    // instr[30] set in an addi immediate must not turn it into a subtract
    drive(32'h40000093, 32'h0, 32'h5, 32'h0, 32'h0);
    chk("addi f7 ignored", alu_out, 32'h405);

    // R-type and shift-immediate with rs1=0x80000000, rs2=4
    drive(32'h402081B3, 32'h0, 32'h80000000, 32'h4, 32'h0);
    chk("sub", alu_out, 32'h7FFFFFFC);
    chk("sub ctrl", {16'h0, ctrl}, 32'h0001);
    drive(32'h4020D1B3, 32'h0, 32'h80000000, 32'h4, 32'h0);
    chk("sra", alu_out, 32'hF8000000);
    drive(32'h0020D1B3, 32'h0, 32'h80000000, 32'h4, 32'h0);
    chk("srl", alu_out, 32'h08000000);
    drive(32'h4040D193, 32'h0, 32'h80000000, 32'h0, 32'h0);
    chk("srai", alu_out, 32'hF8000000);
    chk("srai ctrl", {16'h0, ctrl}, 32'h0006);
    drive(32'h0020A1B3, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("slt", alu_out, 32'h1);
    drive(32'h0020B1B3, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("sltu", alu_out, 32'h0);
    drive(32'h002081B3, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("add wrap", alu_out, 32'h0);
    chk("add wrap zero", {31'h0, zero}, 32'h1);

    // branches
    drive(32'h00208463, 32'h0, 32'h5, 32'h5, 32'h0);
    chk("beq imm",   imm, 32'h8);
    chk("beq zero",  {31'h0, zero}, 32'h1);
    chk("beq taken", {31'h0, br_taken}, 32'h1);
    chk("beq wen",   {31'h0, wen}, 32'h0);
    chk("beq ctrl",  {16'h0, ctrl}, 32'h0020);
    drive(32'h00209463, 32'h0, 32'h5, 32'h5, 32'h0);
    chk("bne taken", {31'h0, br_taken}, 32'h0);
    drive(32'h0020D463, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("bge taken", {31'h0, br_taken}, 32'h0);
    drive(32'h0020C463, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("blt taken", {31'h0, br_taken}, 32'h1);
    drive(32'h0020F463, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("bgeu taken", {31'h0, br_taken}, 32'h1);
    drive(32'h0020A463, 32'h0, 32'h5, 32'h5, 32'h0);
    chk("br f3=010", {31'h0, br_taken}, 32'h0);
    drive(32'hFE208EE3, 32'h0, 32'h5, 32'h5, 32'h0);
    chk("beq neg imm", imm, 32'hFFFFFFFC);

    // loads, load_data = 0x000080F0, base 0x1000
    drive(32'h00008283, 32'h0, 32'h1000, 32'h0, 32'h000080F0);
    chk("lb wb",   wb_data, 32'hFFFFFFF0);
    chk("lb addr", alu_out, 32'h1000);
    chk("lb ctrl", {16'h0, ctrl}, 32'h000A);
    drive(32'h00009283, 32'h0, 32'h1000, 32'h0, 32'h000080F0);
    chk("lh wb",  wb_data, 32'hFFFF80F0);
    drive(32'h0000D283, 32'h0, 32'h1000, 32'h0, 32'h000080F0);
    chk("lhu wb", wb_data, 32'h000080F0);
    drive(32'h0000C283, 32'h0, 32'h1000, 32'h0, 32'h000080F0);
    chk("lbu wb", wb_data, 32'h000000F0);
    drive(32'h0000A283, 32'h0, 32'h1000, 32'h0, 32'h000080F0);
    chk("lw wb",  wb_data, 32'h000080F0);
    @(posedge clk); #1;
    chk("lw wb_q", wb_q, 32'h000080F0);
    chk("lw rd_q", {27'h0, rd_q}, 32'd5);

    // stores
    drive(32'h0020A623, 32'h0, 32'h1000, 32'hAA, 32'h0);
    chk("sw mode", {30'h0, mem_mode}, 32'h3);
    chk("sw wen",  {31'h0, wen}, 32'h0);
    chk("sw addr", alu_out, 32'h100C);
    @(posedge clk); #1;
    chk("sw wen_q", {31'h0, wen_q}, 32'h0);
    drive(32'h00209623, 32'h0, 32'h1000, 32'hAA, 32'h0);
    chk("sh mode", {30'h0, mem_mode}, 32'h2);
    drive(32'h00208623, 32'h0, 32'h1000, 32'hAA, 32'h0);
    chk("sb mode", {30'h0, mem_mode}, 32'h1);
    drive(32'hFE20AE23, 32'h0, 32'h1000, 32'hAA, 32'h0);
    chk("sw neg addr", alu_out, 32'h0FFC);

    // upper-immediate and jumps
    drive(32'h123453B7, 32'h0, 32'h77, 32'h0, 32'h0);
    chk("lui wb",   wb_data, 32'h12345000);
    chk("lui ctrl", {16'h0, ctrl}, 32'h0200);
    drive(32'h00001397, 32'h100, 32'h77, 32'h0, 32'h0);
    chk("auipc wb", wb_data, 32'h1100);
    drive(32'h008000EF, 32'h40, 32'h0, 32'h0, 32'h0);
    chk("jal wb",   wb_data, 32'h44);
    chk("jal imm",  imm, 32'h8);
    drive(32'h004100E7, 32'h40, 32'h2000, 32'h0, 32'h0);
    chk("jalr wb",  wb_data, 32'h44);
    chk("jalr alu", alu_out, 32'h2004);
    chk("jalr ctrl", {16'h0, ctrl}, 32'h0042);
    @(posedge clk); #1;
    chk("jalr wb_q", wb_q, 32'h44);

    drive(32'h0000007F, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("unknown ctrl/wen", {15'h0, wen, ctrl}, 32'h0);

    // asynchronous reset mid-cycle
    drive(32'hFFF00093, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #2;
    chk("pre-rst wb_q", wb_q, 32'hFFFFFFFF);
    rst_n = 1'b0;
    #1;
    chk("async wb_q",  wb_q, 32'h0);
    chk("async rd_q/wen_q", {26'h0, wen_q, rd_q}, 32'h0);
    chk("async wb",    wb_data, 32'h0);
    chk("async alu",   alu_out, 32'h0);
    chk("async imm",   imm, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst wb_q", wb_q, 32'hFFFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
